// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared types and helpers for the instruction fetch stage
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        ALU_OUT  = 2'd1,
        ALU_MOD2 = 2'd2
    } pcmux_sel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } if_state_t;

    localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

    function automatic logic [31:0] next_pc_f(pcmux_sel_t sel, logic [31:0] pc, logic [31:0] alu);
        logic [31:0] npc;
        case (sel)
            ALU_OUT:  npc = alu;
            ALU_MOD2: npc = {alu[31:1], 1'b0};
            default:  npc = pc + 32'd4;
        endcase
        return npc;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - fetch stage bundle: pipeline control, imem handshake, IF/ID outputs
interface if_fetch_unit_if
    import if_fetch_unit_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic             load_buffers;
    pcmux_sel_t       pcmux_sel;
    logic [31:0]      alu_out;
    logic [31:0]      inst_mem_address;
    logic             inst_mem_read;
    logic [31:0]      inst_mem_rdata;
    logic             inst_mem_resp;
    logic             fetch_ready;
    logic [31:0]      if_pc;
    logic [31:0]      if_inst;
    logic             if_valid;
    logic [CNT_W-1:0] squash_count;

    modport master (
        input  load_buffers, pcmux_sel, alu_out, inst_mem_rdata, inst_mem_resp,
        output inst_mem_address, inst_mem_read, fetch_ready, if_pc, if_inst, if_valid, squash_count
    );

    modport slave (
        output load_buffers, pcmux_sel, alu_out, inst_mem_rdata, inst_mem_resp,
        input  inst_mem_address, inst_mem_read, fetch_ready, if_pc, if_inst, if_valid, squash_count
    );
endinterface

// File: rtl/if_fetch_unit_pc_register.sv
// rtl/if_fetch_unit_pc_register.sv - 32-bit program counter with load enable
module if_fetch_unit_pc_register #(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] pc_d_i,
    output logic [31:0] pc_o
);
    logic [31:0] pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else if (load_i) begin
            pc_q <= pc_d_i;
        end
    end

    assign pc_o = pc_q;
endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - IF stage: owns the PC, runs the imem handshake, squashes wrong-path words
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0060,
    parameter int          CNT_W    = 32
) (
    input  logic          clk,
    input  logic          rst,
    if_fetch_unit_if.master bus
);
    if_state_t        state_q, state_d;
    logic [31:0]      inst_q, inst_d;
    logic [31:0]      drain_addr_q, drain_addr_d;
    logic             squashed_q, squashed_d;
    logic [CNT_W-1:0] squash_q, squash_d;
    logic [31:0]      pc, next_pc;
    logic             pc_load;
    logic             redirect;

    assign redirect = bus.load_buffers && (bus.pcmux_sel != PC_PLUS4);
    assign next_pc  = next_pc_f(bus.pcmux_sel, pc, bus.alu_out);

    if_fetch_unit_pc_register #(.RESET_PC(RESET_PC)) u_pc (
        .clk    (clk),
        .rst    (rst),
        .load_i (pc_load),
        .pc_d_i (next_pc),
        .pc_o   (pc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            inst_q       <= RV32I_NOP;
            drain_addr_q <= RESET_PC;
            squashed_q   <= 1'b0;
            squash_q     <= '0;
        end else begin
            state_q      <= state_d;
            inst_q       <= inst_d;
            drain_addr_q <= drain_addr_d;
            squashed_q   <= squashed_d;
            squash_q     <= squash_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        inst_d       = inst_q;
        drain_addr_d = drain_addr_q;
        squashed_d   = squashed_q;
        squash_d     = squash_q;
        pc_load      = 1'b0;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                // A response beats a same-cycle advance; the captured word then belongs to a stale pc.
                if (bus.inst_mem_resp) begin
                    inst_d     = bus.inst_mem_rdata;
                    state_d    = HOLD;
                    squashed_d = bus.load_buffers;
                    pc_load    = bus.load_buffers;
                end else if (bus.load_buffers) begin
                    pc_load = 1'b1;
                    if (redirect) begin
                        drain_addr_d = pc;
                        state_d      = DRAIN;
                    end
                end
            end
            HOLD: begin
                if (bus.load_buffers) begin
                    pc_load    = 1'b1;
                    state_d    = FETCH;
                    squashed_d = 1'b0;
                    if (redirect && (squash_q != '1)) begin
                        squash_d = squash_q + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                pc_load = bus.load_buffers;
                if (bus.inst_mem_resp) begin
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.inst_mem_read    = (state_q == FETCH) || (state_q == DRAIN);
    assign bus.inst_mem_address = (state_q == DRAIN) ? drain_addr_q : pc;
    assign bus.fetch_ready      = (state_q == HOLD);
    assign bus.if_pc            = pc;
    assign bus.if_inst          = inst_q;
    assign bus.if_valid         = (state_q == HOLD) && !redirect && !squashed_q;
    assign bus.squash_count     = squash_q;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - scoreboard bench for if_fetch_unit
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    if_fetch_unit_if #(.CNT_W(2)) bus ();

    if_fetch_unit #(.RESET_PC(32'h0000_0060), .CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic serve(input int wait_n);
        exp_t e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        for (int i = 0; i < wait_n; i++) begin
            check("req_read", 32'(bus.inst_mem_read), 32'd1);
            check("req_addr", bus.inst_mem_address, e.pc);
            check("early_ready", 32'(bus.fetch_ready), 32'd0);
            tick();
        end
        check("resp_addr", bus.inst_mem_address, e.pc);
        bus.inst_mem_rdata = e.inst;
        bus.inst_mem_resp  = 1'b1;
        check("resp_ready", 32'(bus.fetch_ready), 32'd0);
        tick();
        bus.inst_mem_resp = 1'b0;
        check("hold_ready", 32'(bus.fetch_ready), 32'd1);
        check("hold_read", 32'(bus.inst_mem_read), 32'd0);
        check("hold_pc", bus.if_pc, e.pc);
        check("hold_inst", bus.if_inst, e.inst);
        check("hold_valid", 32'(bus.if_valid), 32'(e.valid));
    endtask

    task automatic advance(input pcmux_sel_t sel, input logic [31:0] alu, input logic exp_valid);
        bus.load_buffers = 1'b1;
        bus.pcmux_sel    = sel;
        bus.alu_out      = alu;
        #1;
        check("adv_valid", 32'(bus.if_valid), 32'(exp_valid));
        tick();
        bus.load_buffers = 1'b0;
        bus.pcmux_sel    = PC_PLUS4;
    endtask

    initial begin
        bus.load_buffers   = 1'b0;
        bus.pcmux_sel      = PC_PLUS4;
        bus.alu_out        = 32'd0;
        bus.inst_mem_rdata = 32'd0;
        bus.inst_mem_resp  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_read", 32'(bus.inst_mem_read), 32'd0);
        check("rst_ready", 32'(bus.fetch_ready), 32'd0);
        check("rst_valid", 32'(bus.if_valid), 32'd0);
        check("rst_addr", bus.inst_mem_address, 32'h60);
        check("rst_inst", bus.if_inst, 32'h13);
        check("rst_squash", 32'(bus.squash_count), 32'd0);

        rst = 1'b1;
        tick();
        exp_q.push_back('{pc: 32'h60, inst: 32'h13, valid: 1'b1});
        serve(1);
        advance(PC_PLUS4, 32'd0, 1'b1);
        check("seq_addr", bus.inst_mem_address, 32'h64);

        exp_q.push_back('{pc: 32'h64, inst: 32'hA5A5_0001, valid: 1'b1});
        serve(5);

        advance(ALU_OUT, 32'h200, 1'b0);
        check("squash_1", 32'(bus.squash_count), 32'd1);
        exp_q.push_back('{pc: 32'h200, inst: 32'h1234_5678, valid: 1'b1});
        serve(1);

        advance(ALU_MOD2, 32'h203, 1'b0);
        check("squash_2", 32'(bus.squash_count), 32'd2);
        exp_q.push_back('{pc: 32'h202, inst: 32'h0BAD_F00D, valid: 1'b1});
        serve(1);

        advance(PC_PLUS4, 32'd0, 1'b1);
        bus.load_buffers = 1'b1;
        bus.pcmux_sel    = ALU_OUT;
        bus.alu_out      = 32'h400;
        tick();
        bus.load_buffers = 1'b0;
        bus.pcmux_sel    = PC_PLUS4;
        for (int i = 0; i < 3; i++) begin
            check("drain_read", 32'(bus.inst_mem_read), 32'd1);
            check("drain_addr", bus.inst_mem_address, 32'h206);
            check("drain_ready", 32'(bus.fetch_ready), 32'd0);
            tick();
        end
        bus.inst_mem_rdata = 32'hDEAD_BEEF;
        bus.inst_mem_resp  = 1'b1;
        tick();
        bus.inst_mem_resp = 1'b0;
        check("post_drain_addr", bus.inst_mem_address, 32'h400);
        check("post_drain_ready", 32'(bus.fetch_ready), 32'd0);
        check("post_drain_valid", 32'(bus.if_valid), 32'd0);
        check("post_drain_squash", 32'(bus.squash_count), 32'd2);
        exp_q.push_back('{pc: 32'h400, inst: 32'h0000_1111, valid: 1'b1});
        serve(1);

        advance(ALU_OUT, 32'hFFFF_FFFC, 1'b0);
        check("squash_3", 32'(bus.squash_count), 32'd3);
        exp_q.push_back('{pc: 32'hFFFF_FFFC, inst: 32'h0000_2222, valid: 1'b1});
        serve(1);
        advance(PC_PLUS4, 32'd0, 1'b1);
        check("wrap_addr", bus.inst_mem_address, 32'd0);

        bus.inst_mem_rdata = 32'h0000_3333;
        bus.inst_mem_resp  = 1'b1;
        bus.load_buffers   = 1'b1;
        tick();
        bus.inst_mem_resp = 1'b0;
        bus.load_buffers  = 1'b0;
        check("race_ready", 32'(bus.fetch_ready), 32'd1);
        check("race_valid", 32'(bus.if_valid), 32'd0);
        check("race_pc", bus.if_pc, 32'd4);
        check("race_inst", bus.if_inst, 32'h0000_3333);

        advance(ALU_OUT, 32'h8, 1'b0);
        check("squash_sat", 32'(bus.squash_count), 32'd3);
        check("redir_addr", bus.inst_mem_address, 32'h8);

        bus.load_buffers = 1'b1;
        bus.pcmux_sel    = ALU_OUT;
        bus.alu_out      = 32'h500;
        tick();
        bus.load_buffers = 1'b0;
        bus.pcmux_sel    = PC_PLUS4;
        check("drain2_addr", bus.inst_mem_address, 32'h8);
        check("drain2_read", 32'(bus.inst_mem_read), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check("async_read", 32'(bus.inst_mem_read), 32'd0);
        check("async_addr", bus.inst_mem_address, 32'h60);
        check("async_squash", 32'(bus.squash_count), 32'd0);
        check("async_ready", 32'(bus.fetch_ready), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
